// File: rtl/seven_seg_scan_mux_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment codes,
// the dark-anode level and the blink phase encoding.
package seven_seg_scan_mux_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic       AN_OFF    = 1'b1;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    typedef enum logic {
        PH_SHOW = 1'b0,
        PH_DARK = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/sevseg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment code {g,f,e,d,c,b,a}.
module sevseg_hex_decoder
    import seven_seg_scan_mux_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] code_c_o
);

    always_comb begin
        code_c_o = SEG_HEX_0;
        case (nibble_i)
            4'h0: code_c_o = SEG_HEX_0;
            4'h1: code_c_o = SEG_HEX_1;
            4'h2: code_c_o = SEG_HEX_2;
            4'h3: code_c_o = SEG_HEX_3;
            4'h4: code_c_o = SEG_HEX_4;
            4'h5: code_c_o = SEG_HEX_5;
            4'h6: code_c_o = SEG_HEX_6;
            4'h7: code_c_o = SEG_HEX_7;
            4'h8: code_c_o = SEG_HEX_8;
            4'h9: code_c_o = SEG_HEX_9;
            4'hA: code_c_o = SEG_HEX_A;
            4'hB: code_c_o = SEG_HEX_B;
            4'hC: code_c_o = SEG_HEX_C;
            4'hD: code_c_o = SEG_HEX_D;
            4'hE: code_c_o = SEG_HEX_E;
            4'hF: code_c_o = SEG_HEX_F;
            default: code_c_o = SEG_HEX_0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with frame-aligned data commit and blink.
// Define SEVSEG_LZ_BLANK_EN to build in leading-zero blanking.
module seven_seg_scan_mux
    import seven_seg_scan_mux_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_CNT      = 100000,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [4*NUM_DIGITS-1:0]   din_value,
    input  logic [NUM_DIGITS-1:0]     din_dp,
    input  logic [NUM_DIGITS-1:0]     din_blink,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int unsigned PW = $clog2(DIV_CNT);
    localparam int unsigned IW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned VW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  tick_q, tick_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    blink_phase_e          phase_q, phase_d;
    logic                  ready_q, ready_d;
    logic [VW-1:0]         buf_val_q, buf_val_d, com_val_q, com_val_d;
    logic [NUM_DIGITS-1:0] buf_dp_q, buf_dp_d, com_dp_q, com_dp_d;
    logic [NUM_DIGITS-1:0] buf_blink_q, buf_blink_d, com_blink_q, com_blink_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [NUM_DIGITS-1:0] lz_mask;

    logic       presc_wrap, last_digit;
    logic [3:0] cur_nib;
    logic       cur_dp, cur_blink, cur_lz, dark;
    logic [6:0] hex_code;

    // Scan timing; tick is looked ahead so it is high in the cycle whose edge wraps the index
    always_comb begin
        presc_wrap = (presc_q == PW'(DIV_CNT - 1));
        last_digit = (idx_q == IW'(NUM_DIGITS - 1));
        presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d      = idx_q;
        if (presc_wrap) begin
            idx_d = last_digit ? '0 : idx_q + IW'(1);
        end
        tick_d = (presc_d == PW'(DIV_CNT - 1)) && (idx_d == IW'(NUM_DIGITS - 1));
    end

    // Blink frame counter and phase
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (tick_q) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = (phase_q == PH_DARK) ? PH_SHOW : PH_DARK;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // Single-entry pending buffer; commit only at the frame boundary
    always_comb begin
        ready_d     = ready_q;
        buf_val_d   = buf_val_q;
        buf_dp_d    = buf_dp_q;
        buf_blink_d = buf_blink_q;
        com_val_d   = com_val_q;
        com_dp_d    = com_dp_q;
        com_blink_d = com_blink_q;
        if (din_valid && ready_q) begin
            buf_val_d   = din_value;
            buf_dp_d    = din_dp;
            buf_blink_d = din_blink;
            ready_d     = 1'b0;
        end else if (tick_q && !ready_q) begin
            com_val_d   = buf_val_q;
            com_dp_d    = buf_dp_q;
            com_blink_d = buf_blink_q;
            ready_d     = 1'b1;
        end
    end

`ifdef SEVSEG_LZ_BLANK_EN
    // Dark the run of zero digits (without dp) from the top; digit 0 always shows
    always_comb begin
        logic leading;
        lz_mask = '0;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && (com_val_q[4*i +: 4] == 4'h0) && !com_dp_q[i]) begin
                lz_mask[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = com_val_q[4*i +: 4];
                cur_dp    = com_dp_q[i];
                cur_blink = com_blink_q[i];
                cur_lz    = lz_mask[i];
            end
        end
    end

    sevseg_hex_decoder u_dec (
        .nibble_i (cur_nib),
        .code_c_o (hex_code)
    );

    always_comb begin
        dark  = (cur_blink && (phase_q == PH_DARK)) || cur_lz;
        seg_d = SEG_BLANK;
        an_d  = {NUM_DIGITS{AN_OFF}};
        if (enable) begin
            seg_d = {~cur_dp, hex_code};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (!dark && (idx_q == IW'(i))) begin
                    an_d[i] = ~AN_OFF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            tick_q      <= 1'b0;
            bcnt_q      <= '0;
            phase_q     <= PH_SHOW;
            ready_q     <= 1'b1;
            buf_val_q   <= '0;
            buf_dp_q    <= '0;
            buf_blink_q <= '0;
            com_val_q   <= '0;
            com_dp_q    <= '0;
            com_blink_q <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= {NUM_DIGITS{AN_OFF}};
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            tick_q      <= tick_d;
            bcnt_q      <= bcnt_d;
            phase_q     <= phase_d;
            ready_q     <= ready_d;
            buf_val_q   <= buf_val_d;
            buf_dp_q    <= buf_dp_d;
            buf_blink_q <= buf_blink_d;
            com_val_q   <= com_val_d;
            com_dp_q    <= com_dp_d;
            com_blink_q <= com_blink_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
    assign din_ready  = ready_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Self-checking bench for seven_seg_scan_mux (4 digits, 4-cycle dwell, 2-frame blink).
// Honours SEVSEG_LZ_BLANK_EN the same way the design does.
module tb_seven_seg_scan_mux;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int FRAME = ND * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] din_value;
    logic [3:0]  din_dp;
    logic [3:0]  din_blink;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    seven_seg_scan_mux #(
        .NUM_DIGITS   (ND),
        .DIV_CNT      (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_value  (din_value),
        .din_dp     (din_dp),
        .din_blink  (din_blink),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time is a plain cycle count since reset release
    int          m_c;
    int          m_ticks;
    logic [15:0] m_val, b_val;
    logic [3:0]  m_dp, b_dp, m_blink, b_blink;
    logic        m_pend;
    int          last_d;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [31:0] exp_seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t tbl [3];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, m_c, got, exp);
    endtask

    // One clock: drive inputs, predict, advance model, sample #1 after the edge
    task automatic step(input logic v, input logic [15:0] val, input logic [3:0] dp,
                        input logic [3:0] bl, input logic en);
        int         d;
        logic [3:0] nib, oh, exp_an;
        logic [7:0] exp_seg;
        logic       phase, lz, dark, tick_now;
        din_valid = v;
        din_value = val;
        din_dp    = dp;
        din_blink = bl;
        enable    = en;
        d     = (m_c / DIV) % ND;
        nib   = 4'(m_val >> (4 * d));
        phase = ((m_ticks / BF) % 2) == 1;
`ifdef SEVSEG_LZ_BLANK_EN
        lz = (d > 0) && ((m_val >> (4 * d)) == 16'h0) && ((m_dp >> d) == 4'h0);
`else
        lz = 1'b0;
`endif
        dark    = (m_blink[d] && phase) || lz;
        oh      = 4'(1) << d;
        exp_an  = (en && !dark) ? ~oh : 4'hF;
        exp_seg = en ? {~m_dp[d], hex_tbl[nib]} : 8'hFF;
        tick_now = (m_c % FRAME) == FRAME - 1;
        if (tick_now && m_pend) begin
            m_val = b_val; m_dp = b_dp; m_blink = b_blink; m_pend = 1'b0;
        end else if (v && !m_pend) begin
            b_val = val; b_dp = dp; b_blink = bl; m_pend = 1'b1;
        end
        if (tick_now) m_ticks++;
        m_c++;
        last_d = d;
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(exp_an));
        if (!en || !dark) chk("seg", 32'(seg), 32'(exp_seg));
        chk("frame_tick", 32'(frame_tick), 32'((m_c % FRAME) == FRAME - 1));
        chk("din_ready", 32'(din_ready), 32'(!m_pend));
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0, en);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0; din_value = '0; din_dp = '0; din_blink = '0; enable = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_seg", 32'(seg), 32'h00FF);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_ready", 32'(din_ready), 32'h1);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        m_c = 0; m_ticks = 0; m_pend = 1'b0;
        m_val = '0; m_dp = '0; m_blink = '0;
        b_val = '0; b_dp = '0; b_blink = '0;
        rst = 1'b0;
    endtask

    task automatic load(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] bl);
        int n = 0;
        while (m_pend && n < 3 * FRAME) begin idle(1, 1'b1); n++; end
        step(1'b1, val, dp, bl, 1'b1);
    endtask

    task automatic wait_commit();
        int n = 0;
        while (m_pend && n < 3 * FRAME) begin idle(1, 1'b1); n++; end
        chk("commit_bound", 32'(m_pend), 32'h0);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 32'hF9A4_B099};
        tbl[1] = '{16'hABCD, 4'b0101, 32'h8803_C621};
        tbl[2] = '{16'h8F0E, 4'b0000, 32'h808E_C086};

        do_reset();
        idle(20, 1'b1);

        // Table vectors: commit, then compare one full frame of segment codes
        for (int i = 0; i < 3; i++) begin
            load(tbl[i].value, tbl[i].dp, 4'h0);
            wait_commit();
            for (int k = 0; k < FRAME; k++) begin
                idle(1, 1'b1);
                chk("table_seg", 32'(seg), 32'(8'(tbl[i].exp_seg >> (8 * last_d))));
            end
        end

        // Handshake: second offer while not ready must be dropped
        load(16'hAAAA, 4'h0, 4'h0);
        for (int n = 0; m_pend && n < 3 * FRAME; n++) step(1'b1, 16'h5555, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            idle(1, 1'b1);
            chk("hs_seg", 32'(seg), 32'h88);
        end

        // Accept in the frame_tick cycle commits one frame later
        for (int n = 0; (m_c % FRAME) != FRAME - 1 && n < FRAME; n++) idle(1, 1'b1);
        step(1'b1, 16'h7777, 4'h0, 4'h0, 1'b1);
        wait_commit();
        idle(FRAME, 1'b1);

        // Blink on digit 0
        load(16'h1234, 4'h0, 4'b0001);
        wait_commit();
        idle(6 * FRAME, 1'b1);

        // Display dark while scan and ticks continue
        idle(5, 1'b1);
        idle(40, 1'b0);
        idle(8, 1'b1);

        // Leading zeros
        load(16'h0050, 4'h0, 4'h0);
        wait_commit();
        idle(2 * FRAME, 1'b1);
        load(16'h0000, 4'b0100, 4'h0);
        wait_commit();
        idle(FRAME, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 7) != 0);
        end

        // Reset with data pending discards it
        load(16'h4321, 4'hF, 4'h0);
        idle(3, 1'b1);
        do_reset();
        idle(2 * FRAME, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
